// File: rtl/fp_mul_special_pipe.sv
// fp_mul_special_pipe: two-stage special-operand (NaN/zero/inf) resolver for an FP multiplier.
// Optional sticky invalid/sNaN flags are built when FP_MUL_SPECIAL_FLAGS_EN is defined.
module fp_mul_special_pipe #(
  parameter int EXP_W     = 8,
  parameter int MANT_W    = 23,
  parameter bit QNAN_SIGN = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [EXP_W+MANT_W:0]       op_a,
  input  logic [EXP_W+MANT_W:0]       op_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [EXP_W+MANT_W:0]       result,
  output logic                        special,
  output logic [3:0]                  spec_case
`ifdef FP_MUL_SPECIAL_FLAGS_EN
  ,
  input  logic                        flags_clr,
  output logic                        flag_invalid,
  output logic                        flag_snan
`endif
);
  localparam int W = 1 + EXP_W + MANT_W;
  localparam logic [W-1:0] QBIT = {{(EXP_W+1){1'b0}}, 1'b1, {(MANT_W-1){1'b0}}};
  logic w_a_eone, w_a_ezero, w_a_mz, w_b_eone, w_b_ezero, w_b_mz;
  logic w_a_nan, w_a_inf, w_a_zero, w_b_nan, w_b_inf, w_b_zero;
  logic [W-1:0] w_nan_sel;
  logic w_ld1, w_ld2;
  logic r1_v, r1_an, r1_ai, r1_az, r1_bn, r1_bi, r1_bz, r1_s;
  logic [W-1:0] r1_nan;
  logic w_zi_raw, w_zero_any, w_inf_any;
  logic [3:0] w_case;
  logic [W-1:0] w_res;
  logic r2_v, r2_sp;
  logic [3:0] r2_case;
  logic [W-1:0] r2_res;
  assign w_a_eone  = &op_a[W-2:MANT_W];
  assign w_a_ezero = ~|op_a[W-2:MANT_W];
  assign w_a_mz    = ~|op_a[MANT_W-1:0];
  assign w_b_eone  = &op_b[W-2:MANT_W];
  assign w_b_ezero = ~|op_b[W-2:MANT_W];
  assign w_b_mz    = ~|op_b[MANT_W-1:0];
  assign w_a_nan   = w_a_eone & ~w_a_mz;
  assign w_a_inf   = w_a_eone & w_a_mz;
  assign w_a_zero  = w_a_ezero & w_a_mz;
  assign w_b_nan   = w_b_eone & ~w_b_mz;
  assign w_b_inf   = w_b_eone & w_b_mz;
  assign w_b_zero  = w_b_ezero & w_b_mz;
  assign w_nan_sel = w_a_nan ? op_a : op_b;
  // Stage 2 advances when empty or draining; stage 1 when empty or stage 2 takes its content.
  assign w_ld2    = ~r2_v | out_ready;
  assign w_ld1    = ~r1_v | w_ld2;
  assign in_ready = w_ld1;
  // Stage 1: register operand classes, product sign and the raw NaN candidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v   <= 1'b0;
      r1_an  <= 1'b0;
      r1_ai  <= 1'b0;
      r1_az  <= 1'b0;
      r1_bn  <= 1'b0;
      r1_bi  <= 1'b0;
      r1_bz  <= 1'b0;
      r1_s   <= 1'b0;
      r1_nan <= '0;
    end else if (w_ld1) begin
      r1_v <= in_valid;
      if (in_valid) begin
        r1_an  <= w_a_nan;
        r1_ai  <= w_a_inf;
        r1_az  <= w_a_zero;
        r1_bn  <= w_b_nan;
        r1_bi  <= w_b_inf;
        r1_bz  <= w_b_zero;
        r1_s   <= op_a[W-1] ^ op_b[W-1];
        r1_nan <= w_nan_sel;
      end
    end
  end
  // Resolve the case with NaN > 0*inf > zero*num > inf*num priority, keeping spec_case one-hot.
  always_comb begin
    w_zi_raw   = (r1_az & r1_bi) | (r1_ai & r1_bz);
    w_zero_any = r1_az | r1_bz;
    w_inf_any  = r1_ai | r1_bi;
    w_case[3]  = r1_an | r1_bn;
    w_case[2]  = ~w_case[3] & w_zi_raw;
    w_case[1]  = ~w_case[3] & ~w_zi_raw & w_zero_any;
    w_case[0]  = ~w_case[3] & ~w_zi_raw & ~w_zero_any & w_inf_any;
    w_res = w_case[3] ? (r1_nan | QBIT) :
            w_case[2] ? {QNAN_SIGN, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}} :
            w_case[0] ? {r1_s, {EXP_W{1'b1}}, {MANT_W{1'b0}}} :
                        {r1_s, {(W-1){1'b0}}};
  end
  // Stage 2: register the final result; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_v    <= 1'b0;
      r2_sp   <= 1'b0;
      r2_case <= 4'd0;
      r2_res  <= '0;
    end else if (w_ld2) begin
      r2_v <= r1_v;
      if (r1_v) begin
        r2_sp   <= |w_case;
        r2_case <= w_case;
        r2_res  <= w_res;
      end
    end
  end
  assign out_valid = r2_v;
  assign result    = r2_res;
  assign special   = r2_sp;
  assign spec_case = r2_case;
`ifdef FP_MUL_SPECIAL_FLAGS_EN
  logic r1_snan, r2_inv, r2_snan, r_flag_inv, r_flag_snan, w_fire;
  assign w_fire = r2_v & out_ready;
  // Carry the "any input was a signalling NaN" bit alongside stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r1_snan <= 1'b0;
    else if (w_ld1 && in_valid) r1_snan <= (w_a_nan & ~op_a[MANT_W-1]) | (w_b_nan & ~op_b[MANT_W-1]);
  end
  // Invalid covers 0*inf and quieting of a signalling NaN selected as the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_inv  <= 1'b0;
      r2_snan <= 1'b0;
    end else if (w_ld2 && r1_v) begin
      r2_inv  <= w_case[2] | (w_case[3] & ~r1_nan[MANT_W-1]);
      r2_snan <= r1_snan;
    end
  end
  // Sticky flags update on output transfers; a set beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_inv  <= 1'b0;
      r_flag_snan <= 1'b0;
    end else begin
      r_flag_inv  <= (w_fire & r2_inv) | (r_flag_inv & ~flags_clr);
      r_flag_snan <= (w_fire & r2_snan) | (r_flag_snan & ~flags_clr);
    end
  end
  assign flag_invalid = r_flag_inv;
  assign flag_snan    = r_flag_snan;
`endif
endmodule

// File: doc/fp_mul_special_pipe.md
# fp_mul_special_pipe

Pipelined, parametrised special-operand stage for the floating-point multiplier. Each cycle it accepts one operand pair over a valid/ready handshake and classifies both operands as NaN, zero, infinity or ordinary number. It then emits either the final IEEE-style special result or a "not special" indication, so the downstream mantissa/exponent datapath handles the operation. It sits between the operand input register and the multiplier core, and supports any EXP_W/MANT_W format.

## Interface
- EXP_W, 8, exponent width; must be ≥ 2
- MANT_W, 23, stored mantissa width without the hidden bit; must be ≥ 2
- QNAN_SIGN, 1, sign bit of the default NaN produced for 0·inf
- W (derived localparam) = 1 + EXP_W + MANT_W

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair this cycle
- op_a  in  W  operand A as {sign, exp, mant}
- op_b  in  W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- result  out  W  special result, or {sign_a^sign_b, 0…0} when not special
- special  out  1  result is final and the core must be bypassed
- spec_case  out  4  one-hot class or 0: [3] NaN, [2] 0·inf, [1] zero·num, [0] inf·num

## Operation
Classification, per operand:
- nan: exp all-ones, mant ≠ 0
- inf: exp all-ones, mant = 0
- zero: exp = 0, mant = 0
- Denormals count as ordinary numbers.

Case priority and result:
- NaN: takes A if A is NaN, otherwise B. Output is that operand with the mantissa MSB forced to 1 (quieted). Sign, exponent and the remaining mantissa bits pass through unchanged.
- 0·inf (either order): {QNAN_SIGN, all-ones, 1, 0…0}.
- zero·num: {sa^sb, 0, 0}.
- inf·num: {sa^sb, all-ones, 0}.
- None of the above: special = 0, spec_case = 0, result = {sa^sb, 0, 0}.

Pipeline:
- Stage 1 registers the classification bits, signs and the selected NaN payload.
- Stage 2 registers result, special and spec_case.
- Each stage has its own valid bit. A stage loads when it is empty or when its contents move on in the same cycle.
- in_ready = !v1 || !v2 || out_ready.
- out_valid = v2.
- A transfer occurs only on valid && ready. Order is preserved and no pair is dropped or duplicated.
- While out_valid is high and out_ready is low, result, special and spec_case stay stable.

## Timing
- Latency: 2 cycles from an input transfer to out_valid, given an empty pipe and out_ready = 1.
- Throughput: 1 pair per cycle while out_ready stays high.
- Under backpressure, the block holds at most 2 pairs. in_ready falls only when both stages are full and out_ready = 0.
- Reset values: out_valid 0, result 0, special 0, spec_case 0. in_ready is 1 once rst_n is high.
- Assertion of rst_n mid-operation flushes both stages immediately. In-flight pairs are discarded and never appear at the output.
- in_ready depends combinationally on out_ready. No other input-to-output combinational path exists.

## Configuration
- Macro FP_MUL_SPECIAL_FLAGS_EN adds three ports:
  - flags_clr  in  1
  - flag_invalid  out  1
  - flag_snan  out  1
- With the macro defined:
  - flag_invalid is sticky. It sets on an output transfer of a 0·inf case, or of a NaN case whose selected input had mantissa MSB = 0.
  - flag_snan sets on an output transfer where either input was a signalling NaN.
  - flags_clr clears both flags. If a set and flags_clr occur in the same cycle, the set wins.
  - Both flags reset to 0.
- Without the macro, these ports and registers do not exist. Datapath behaviour is identical in both builds.

## Test plan
- 0x7F800000 × 0x00000000 → result 0xFFC00000, spec_case 4'b0100, special 1, 2 cycles after the transfer.
- 0x3F800000 × 0x7FA00001 → 0x7FE00001, spec_case 4'b1000. With FLAGS_EN: flag_invalid = 1 and flag_snan = 1. flags_clr then drops both to 0.
- 0x80000000 × 0x40000000 → 0x80000000, spec_case 4'b0010. 0x3F800000 × 0x40000000 → special 0, result 0x00000000.
- EXP_W=5, MANT_W=10: 0xFC00 × 0x3C00 → 0xFC00, spec_case 4'b0001.
- Hold out_ready = 0 and send 3 pairs back-to-back:
  - in_ready falls after the 2nd pair is accepted.
  - result stays stable while stalled.
  - Releasing out_ready delivers all 3 in order with no loss.
- Pull rst_n low while 2 pairs are in flight → out_valid drops to 0 asynchronously. Nothing from those pairs appears after release.
